// File: rtl/plate_spawner_pkg.sv
// -----------------------------------------------------------------------------
// plate_pkg
//   Shared types and constants for the plate spawner and the plate drawers.
//   spawn_state_t : spawner FSM state encoding
//   LFSR_TAPS     : Galois feedback mask of the 16-bit layout LFSR
//   coord_t       : 20-bit world coordinate
//   DEFAULT_*     : screen / plate geometry shared with the drawers
// -----------------------------------------------------------------------------
package plate_pkg;
    typedef enum logic [1:0] {INIT, IDLE, SCAN} spawn_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [19:0] coord_t;

    localparam int DEFAULT_SCREEN_W = 640;
    localparam int DEFAULT_PLATE_W  = 64;
    localparam int DEFAULT_PLATE_H  = 16;
endpackage

// File: rtl/plate_spawner_if.sv
// -----------------------------------------------------------------------------
// plate_spawner_if
//   Bundle between game logic / plate drawers (master) and the spawner (slave).
//   replay, frame          : control pulses from game logic
//   screen_height          : current world scroll height
//   rd_idx                 : read-port slot select
//   plate_x_init/_y_init   : table contents of slot rd_idx
//   top_y                  : highest plate y in the table
//   busy                   : spawner is in INIT or SCAN
// -----------------------------------------------------------------------------
interface plate_spawner_if #(
    parameter int N_PLATES = 8,
    parameter int CORDW    = 20
);
    localparam int IDX_W = $clog2(N_PLATES);

    logic             replay;
    logic             frame;
    logic [CORDW-1:0] screen_height;
    logic [IDX_W-1:0] rd_idx;
    logic [CORDW-1:0] plate_x_init;
    logic [CORDW-1:0] plate_y_init;
    logic [CORDW-1:0] top_y;
    logic             busy;

    modport master (
        output replay, frame, screen_height, rd_idx,
        input  plate_x_init, plate_y_init, top_y, busy
    );

    modport slave (
        input  replay, frame, screen_height, rd_idx,
        output plate_x_init, plate_y_init, top_y, busy
    );
endinterface

// File: rtl/plate_spawner_lfsr.sv
// -----------------------------------------------------------------------------
// plate_lfsr
//   16-bit right-shifting Galois LFSR (feedback mask LFSR_TAPS).
//   clk, rst : clock, asynchronous active-high reset (loads SEED)
//   en       : advance one step
//   q        : current LFSR state
// -----------------------------------------------------------------------------
module plate_lfsr
    import plate_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= SEED;
        else if (en)
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
endmodule

// File: rtl/plate_spawner.sv
// -----------------------------------------------------------------------------
// plate_spawner
//   Owns the world-space table of plate positions. After reset/replay it lays
//   out N_PLATES plates (INIT); on every frame pulse it scans all slots (SCAN)
//   and recycles plates that have scrolled below the screen bottom to
//   top_y + gap with a pseudo-random x.
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : plate_spawner_if.slave (replay, frame, screen_height, rd_idx in;
//          plate_x_init, plate_y_init, top_y, busy out)
//   Optional macro PLATE_SPAWNER_GAP_RAMP_EN: adds a difficulty ramp to the
//   gap that grows by one every 16 recycles, saturating at 31.
// -----------------------------------------------------------------------------
module plate_spawner
    import plate_pkg::*;
#(
    parameter int          N_PLATES  = 8,
    parameter int          CORDW     = 20,
    parameter int          SCREEN_W  = DEFAULT_SCREEN_W,
    parameter int          PLATE_W   = DEFAULT_PLATE_W,
    parameter int          PLATE_H   = DEFAULT_PLATE_H,
    parameter int          GAP_BASE  = 48,
    parameter int          GAP_RND_W = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    plate_spawner_if.slave bus
);
    localparam int               IDX_W     = $clog2(N_PLATES);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(N_PLATES - 1);
    localparam logic [9:0]       X_SPAN    = 10'(SCREEN_W - PLATE_W);
    localparam logic [CORDW-1:0] X_CENTER  = CORDW'((SCREEN_W - PLATE_W) / 2);
    localparam logic [CORDW-1:0] GAP_BASE_C = CORDW'(GAP_BASE);
    localparam logic [CORDW-1:0] TOP_INIT  = CORDW'((N_PLATES - 1) * GAP_BASE);
    localparam logic [CORDW:0]   PLATE_H_C = (CORDW+1)'(PLATE_H);

    spawn_state_t     state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [CORDW-1:0] top_y, top_next;
    logic [CORDW-1:0] x_tab [N_PLATES];
    logic [CORDW-1:0] y_tab [N_PLATES];
    logic             wr_en;
    logic [CORDW-1:0] wr_x, wr_y;
    logic             recycle;
    logic             off_screen;
    logic [CORDW-1:0] gap;
    logic [CORDW-1:0] rnd_x;
    logic [15:0]      lfsr;
    logic             unused_lfsr_hi;

    // Fold r = lfsr[9:0] into [0, SCREEN_W-PLATE_W) with a single subtract.
    function automatic logic [CORDW-1:0] rand_x(input logic [15:0] l);
        logic [9:0] r;
        r = l[9:0];
        if (r >= X_SPAN)
            r = r - X_SPAN;
        return {{(CORDW-10){1'b0}}, r};
    endfunction

    plate_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:10];
    assign rnd_x          = rand_x(lfsr);

    // Widened by one bit so plates near 2^CORDW never look off-screen.
    assign off_screen = ({1'b0, y_tab[ptr]} + PLATE_H_C) <= {1'b0, bus.screen_height};

`ifdef PLATE_SPAWNER_GAP_RAMP_EN
    logic [4:0] ramp;
    logic [3:0] rec_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp    <= '0;
            rec_cnt <= '0;
        end else if (bus.replay) begin
            ramp    <= '0;
            rec_cnt <= '0;
        end else if (recycle) begin
            rec_cnt <= rec_cnt + 4'd1;
            if (rec_cnt == 4'd15 && ramp != 5'd31)
                ramp <= ramp + 5'd1;
        end
    end

    assign gap = GAP_BASE_C + CORDW'(ramp) + CORDW'(lfsr[GAP_RND_W-1:0]);
`else
    assign gap = GAP_BASE_C + CORDW'(lfsr[GAP_RND_W-1:0]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
            top_y <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            top_y <= top_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        top_next   = top_y;
        wr_en      = 1'b0;
        wr_x       = rnd_x;
        wr_y       = '0;
        recycle    = 1'b0;
        // replay wins over everything, including the current slot's write.
        if (bus.replay) begin
            state_next = INIT;
            ptr_next   = '0;
        end else begin
            case (state)
                INIT: begin
                    wr_en = 1'b1;
                    wr_y  = CORDW'(ptr) * GAP_BASE_C;
                    wr_x  = (ptr == '0) ? X_CENTER : rnd_x;
                    if (ptr == LAST) begin
                        top_next   = TOP_INIT;
                        state_next = IDLE;
                        ptr_next   = '0;
                    end else begin
                        ptr_next = ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.frame) begin
                        state_next = SCAN;
                        ptr_next   = '0;
                    end
                end
                SCAN: begin
                    if (off_screen) begin
                        recycle  = 1'b1;
                        wr_en    = 1'b1;
                        wr_y     = top_y + gap;
                        top_next = top_y + gap;
                    end
                    if (ptr == LAST) begin
                        state_next = IDLE;
                        ptr_next   = '0;
                    end else begin
                        ptr_next = ptr + 1'b1;
                    end
                end
                default: begin
                    state_next = INIT;
                    ptr_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PLATES; i++) begin
                x_tab[i] <= '0;
                y_tab[i] <= '0;
            end
        end else if (wr_en) begin
            x_tab[ptr] <= wr_x;
            y_tab[ptr] <= wr_y;
        end
    end

    assign bus.plate_x_init = x_tab[bus.rd_idx];
    assign bus.plate_y_init = y_tab[bus.rd_idx];
    assign bus.top_y        = top_y;
    assign bus.busy         = (state != IDLE);
endmodule
